// File: rtl/ysyx_22050039_pkg.sv
// Shared types and constants for the ysyx_22050039 fetch slice.
// No logic; no latency; no flow control.
// Holds the fetch FSM encoding, instruction width and default boot address.
package ysyx_22050039_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

    localparam int          INST_W           = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050039_Reg.sv
// Generic register with synchronous active-high reset and write enable.
// Latency: 1 cycle from din to dout.
// Backpressure: none; wen gates the update.
module ysyx_22050039_Reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_22050039_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one held instruction for the IDU.
// Latency: 3 cycles minimum per instruction (request accept, response, consume).
// Backpressure: stalls in REQ until imem_req_ready and in OUT until inst_ready; YSYX_22050039_FETCH_PERF_EN adds perf counters.
module ysyx_22050039_fetch_ctrl
    import ysyx_22050039_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic [XLEN-1:0]   pc
`ifdef YSYX_22050039_FETCH_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_flush_cnt
`endif
);

    fetch_state_e    state, state_nxt;
    logic            flush, flush_nxt;
    logic            capture;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_inc;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign pc_inc           = pc + XLEN'(4);
    assign imem_req_addr    = pc;

    ysyx_22050039_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (pc_nxt),
        .dout (pc),
        .wen  (1'b1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            flush   <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state <= state_nxt;
            flush <= flush_nxt;
            if (capture) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush;
        pc_nxt    = pc;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_valid) pc_nxt = redirect_aligned;
            end
            S_REQ: begin
                if (redirect_valid) pc_nxt = redirect_aligned;
                // A redirect on the accept cycle means memory saw the stale address.
                if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                    flush_nxt = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush || redirect_valid) begin
                        state_nxt = S_REQ;
                        flush_nxt = 1'b0;
                        if (redirect_valid) pc_nxt = redirect_aligned;
                    end else begin
                        state_nxt = S_OUT;
                        capture   = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_aligned;
                    flush_nxt = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_nxt = S_REQ;
                    pc_nxt    = redirect_aligned;
                end else if (inst_ready) begin
                    state_nxt = S_REQ;
                    pc_nxt    = pc_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            S_REQ:   imem_req_valid = 1'b1;
            S_OUT:   inst_valid     = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_22050039_FETCH_PERF_EN
    logic delivered;
    logic dropped;

    assign delivered = (state == S_OUT) && inst_ready && !redirect_valid;
    assign dropped   = ((state == S_WAIT) && imem_rsp_valid && (flush || redirect_valid))
                     || ((state == S_OUT) && redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (delivered && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (dropped && (perf_flush_cnt != '1))   perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050039_fetch_ctrl.sv
// Bench for ysyx_22050039_fetch_ctrl: directed scenarios plus randomized traffic against a flag-based reference model.
// A small memory responder returns addr-derived words after a configurable delay.
module tb_ysyx_22050039_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] pc;
`ifdef YSYX_22050039_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_flush_cnt;
`endif

    ysyx_22050039_fetch_ctrl #(
        .XLEN     (64),
        .RESET_PC (64'h0000_0000_8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc             (pc)
`ifdef YSYX_22050039_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: flags describing what the fetcher is doing, not an FSM encoding.
    bit          m_starting;   // the one dead cycle after reset
    bit          m_waiting;    // a request is outstanding at memory
    bit          m_holding;    // an instruction is being offered
    bit          m_stale;      // the outstanding response must be thrown away
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_inst_pc;
    logic [63:0] m_deliv;
    logic [63:0] m_drop;

    bit          mem_pend;
    logic [63:0] mem_addr;
    int          mem_wait;
    int          dly_min = 0;
    int          dly_max = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] align4(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

    task automatic model_step(input bit r, input bit rdy, input bit rv, input bit ir, input bit rd,
                              input logic [63:0] rpc, input logic [31:0] rdata);
        if (r) begin
            m_starting = 1; m_waiting = 0; m_holding = 0; m_stale = 0;
            m_pc = RST_PC; m_inst = '0; m_inst_pc = '0; m_deliv = '0; m_drop = '0;
        end else if (m_starting) begin
            m_starting = 0;
            if (rd) m_pc = align4(rpc);
        end else if (m_holding) begin
            if (rd) begin
                m_holding = 0; m_pc = align4(rpc); m_drop = m_drop + 1;
            end else if (ir) begin
                m_holding = 0; m_pc = m_pc + 64'd4; m_deliv = m_deliv + 1;
            end
        end else if (m_waiting) begin
            if (rv) begin
                m_waiting = 0;
                if (m_stale || rd) begin
                    m_stale = 0; m_drop = m_drop + 1;
                    if (rd) m_pc = align4(rpc);
                end else begin
                    m_holding = 1; m_inst = rdata; m_inst_pc = m_pc;
                end
            end else if (rd) begin
                m_pc = align4(rpc); m_stale = 1;
            end
        end else begin
            if (rd) m_pc = align4(rpc);
            if (rdy) begin
                m_waiting = 1; m_stale = rd;
            end
        end
    endtask

    // One clock: drive inputs after negedge, advance model/memory at posedge, return at next negedge.
    task automatic step(input bit r, input bit rdy, input bit ir, input bit rd,
                        input logic [63:0] rpc, input bit inject);
        bit          rv;
        bit          hs;
        logic [63:0] haddr;
        logic [31:0] rdata;
        rv    = inject || (mem_pend && mem_wait == 0);
        rdata = inject ? 32'hDEAD_BEEF : (rv ? mem_word(mem_addr) : $urandom);
        rst            = r;
        imem_req_ready = rdy;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdata;
        hs    = imem_req_valid && rdy;
        haddr = imem_req_addr;
        @(posedge clk);
        model_step(r, rdy, rv, ir, rd, rpc, rdata);
        if (r) begin
            mem_pend = 0;
        end else begin
            if (rv && !inject) mem_pend = 0;
            else if (mem_pend && mem_wait > 0) mem_wait--;
            if (hs) begin
                mem_pend = 1; mem_addr = haddr;
                mem_wait = $urandom_range(dly_max, dly_min);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 64'd0, 0);
        step(1, 1, 1, 0, 64'd0, 0);
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        vectors++; if (pc !== RST_PC) begin miscompares++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
        vectors++; if (inst !== 32'd0) begin miscompares++; $display("FAIL reset_inst got %h exp 0", inst); end
        vectors++; if (inst_pc !== 64'd0) begin miscompares++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    endtask

    task automatic test_stream;
        logic [63:0] pcs[$];
        logic [31:0] words[$];
        int          when[$];
        dly_min = 0; dly_max = 0;
        step(0, 1, 1, 0, 64'd0, 0);
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            miscompares++; $display("FAIL stream_first_req got v=%b a=%h exp v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 0, 64'd0, 0);
            if (inst_valid) begin pcs.push_back(inst_pc); words.push_back(inst); when.push_back(i); end
        end
        vectors++; if (pcs.size() != 3) begin miscompares++; $display("FAIL stream_count got %0d exp 3", pcs.size()); end
        for (int k = 0; k < pcs.size() && k < 3; k++) begin
            vectors++; if (pcs[k] !== RST_PC + 64'(4 * k)) begin miscompares++; $display("FAIL stream_pc%0d got %h exp %h", k, pcs[k], RST_PC + 64'(4 * k)); end
            vectors++; if (words[k] !== mem_word(RST_PC + 64'(4 * k))) begin miscompares++; $display("FAIL stream_inst%0d got %h exp %h", k, words[k], mem_word(RST_PC + 64'(4 * k))); end
            if (k > 0) begin
                vectors++; if (when[k] - when[k-1] != 3) begin miscompares++; $display("FAIL stream_gap%0d got %0d exp 3", k, when[k] - when[k-1]); end
            end
        end
    endtask

    task automatic test_stall;
        dly_min = 0; dly_max = 0;
        step(1, 0, 0, 0, 64'd0, 0);
        step(0, 0, 1, 0, 64'd0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 64'd0, 0);
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
                miscompares++; $display("FAIL stall_%0d got v=%b a=%h iv=%b exp v=1 a=%h iv=0", i, imem_req_valid, imem_req_addr, inst_valid, RST_PC);
            end
        end
        step(0, 1, 0, 0, 64'd0, 0);
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_accept got %b exp 0", imem_req_valid); end
        step(0, 0, 0, 0, 64'd0, 0);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
            miscompares++; $display("FAIL stall_deliver got iv=%b pc=%h exp iv=1 pc=%h", inst_valid, inst_pc, RST_PC);
        end
    endtask

    task automatic test_redirect_wait;
        bit seen = 0;
        bit leak = 0;
        dly_min = 2; dly_max = 2;
        step(1, 0, 0, 0, 64'd0, 0);
        step(0, 0, 1, 0, 64'd0, 0);
        step(0, 1, 1, 0, 64'd0, 0);
        step(0, 0, 1, 1, 64'h0000_0000_8000_1003, 0);
        vectors++; if (pc !== 64'h0000_0000_8000_1000) begin miscompares++; $display("FAIL rwait_pc got %h exp 80001000", pc); end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 64'd0, 0);
            if (inst_valid) leak = 1;
            if (imem_req_valid && !seen) begin
                seen = 1;
                vectors++; if (imem_req_addr !== 64'h0000_0000_8000_1000) begin miscompares++; $display("FAIL rwait_addr got %h exp 80001000", imem_req_addr); end
            end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL rwait_timeout got no request exp request within 8 cycles"); end
        vectors++; if (leak) begin miscompares++; $display("FAIL rwait_leak got inst_valid=1 exp 0"); end
    endtask

    task automatic test_redirect_out;
        dly_min = 0; dly_max = 0;
        step(1, 0, 0, 0, 64'd0, 0);
        step(0, 1, 0, 0, 64'd0, 0);
        step(0, 1, 0, 0, 64'd0, 0);
        step(0, 1, 0, 0, 64'd0, 0);
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL rout_hold got %b exp 1", inst_valid); end
        step(0, 0, 1, 1, 64'h0000_0000_8000_0100, 0);
        vectors++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0000_0000_8000_0100) begin
            miscompares++; $display("FAIL rout_next got iv=%b v=%b a=%h exp iv=0 v=1 a=80000100", inst_valid, imem_req_valid, imem_req_addr);
        end
`ifdef YSYX_22050039_FETCH_PERF_EN
        vectors++; if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd1) begin
            miscompares++; $display("FAIL rout_perf got f=%0d d=%0d exp f=0 d=1", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_reset_wait;
        dly_min = 3; dly_max = 3;
        step(1, 0, 0, 0, 64'd0, 0);
        step(0, 0, 1, 0, 64'd0, 0);
        step(0, 1, 1, 0, 64'd0, 0);
        step(1, 0, 1, 0, 64'd0, 0);
        step(0, 0, 1, 0, 64'd0, 1);
        vectors++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            miscompares++; $display("FAIL rstw_idle got iv=%b v=%b a=%h exp iv=0 v=1 a=%h", inst_valid, imem_req_valid, imem_req_addr, RST_PC);
        end
        step(0, 0, 1, 0, 64'd0, 1);
        vectors++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            miscompares++; $display("FAIL rstw_req got iv=%b v=%b a=%h exp iv=0 v=1 a=%h", inst_valid, imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

`ifdef YSYX_22050039_FETCH_PERF_EN
    task automatic test_perf;
        dly_min = 0; dly_max = 0;
        step(1, 0, 0, 0, 64'd0, 0);
        vectors++; if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd0) begin
            miscompares++; $display("FAIL perf_reset got f=%0d d=%0d exp 0 0", perf_fetch_cnt, perf_flush_cnt);
        end
        for (int i = 0; i < 13; i++) step(0, 1, 1, 0, 64'd0, 0);
        step(0, 1, 0, 0, 64'd0, 0);
        step(0, 1, 0, 0, 64'd0, 0);
        step(0, 1, 1, 1, RST_PC + 64'h40, 0);
        vectors++; if (perf_fetch_cnt !== 64'd4 || perf_flush_cnt !== 64'd1) begin
            miscompares++; $display("FAIL perf_counts got f=%0d d=%0d exp f=4 d=1", perf_fetch_cnt, perf_flush_cnt);
        end
    endtask
`endif

    task automatic test_random;
        dly_min = 0; dly_max = 3;
        step(1, 0, 0, 0, 64'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199, 0) == 0, $urandom_range(9, 0) < 6, $urandom_range(9, 0) < 7,
                 $urandom_range(7, 0) == 0, {$urandom, $urandom}, 0);
            vectors++; if (imem_req_valid !== (!m_starting && !m_waiting && !m_holding)) begin
                miscompares++; $display("FAIL rand_req_valid cyc %0d got %b exp %b", i, imem_req_valid, !m_starting && !m_waiting && !m_holding);
            end
            vectors++; if (imem_req_addr !== m_pc || pc !== m_pc) begin
                miscompares++; $display("FAIL rand_pc cyc %0d got addr=%h pc=%h exp %h", i, imem_req_addr, pc, m_pc);
            end
            vectors++; if (inst_valid !== m_holding) begin
                miscompares++; $display("FAIL rand_inst_valid cyc %0d got %b exp %b", i, inst_valid, m_holding);
            end
            vectors++; if (inst !== m_inst || inst_pc !== m_inst_pc) begin
                miscompares++; $display("FAIL rand_inst cyc %0d got %h@%h exp %h@%h", i, inst, inst_pc, m_inst, m_inst_pc);
            end
`ifdef YSYX_22050039_FETCH_PERF_EN
            vectors++; if (perf_fetch_cnt !== m_deliv || perf_flush_cnt !== m_drop) begin
                miscompares++; $display("FAIL rand_perf cyc %0d got f=%0d d=%0d exp f=%0d d=%0d", i, perf_fetch_cnt, perf_flush_cnt, m_deliv, m_drop);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
        mem_pend = 0; mem_addr = '0; mem_wait = 0;
        @(negedge clk);
        test_reset;
        test_stream;
        test_stall;
        test_redirect_wait;
        test_redirect_out;
        test_reset_wait;
`ifdef YSYX_22050039_FETCH_PERF_EN
        test_perf;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_22050039_fetch_ctrl.md
YSYX_22050039_FETCH_CTRL -- requirements
Module: ysyx_22050039_fetch_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 64'h80000000, first fetch address.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port redirect_valid  in  1  EXU branch/jump taken.
REQ-006 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-007 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  out  XLEN  fetch address.
REQ-010 SHALL have port imem_rsp_valid  in  1  instruction data returned.
REQ-011 SHALL have port imem_rsp_data  in  32  returned instruction.
REQ-012 SHALL have port inst_valid  out  1  instruction offered to IDU.
REQ-013 SHALL have port inst_ready  in  1  IDU consumes instruction.
REQ-014 SHALL have port inst  out  32  held instruction.
REQ-015 SHALL have port inst_pc  out  XLEN  PC of held instruction.
REQ-016 SHALL have port pc  out  XLEN  current fetch PC.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, OUT; at most one outstanding memory request.
REQ-018 IDLE: all valids low; unconditional transition to REQ next cycle.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT; else stay REQ.
REQ-020 WAIT: on imem_rsp_valid with no flush pending and no redirect -> capture inst<=imem_rsp_data, inst_pc<=pc, -> OUT.
REQ-021 OUT: inst_valid=1, inst/inst_pc stable until consumed; on inst_ready -> pc<=pc+4, -> REQ.
REQ-022 Minimum per-instruction latency SHALL be 3 cycles (REQ accept, WAIT response, OUT consume); response is legal no earlier than the cycle after acceptance.
REQ-023 Redirect in REQ without handshake: pc<=redirect_pc, stay REQ; the address is sampled by memory only on handshake.
REQ-024 Redirect in REQ with handshake same cycle: pc<=redirect_pc, flush<=1, -> WAIT.
REQ-025 Redirect in WAIT without response: pc<=redirect_pc, flush<=1.
REQ-026 Response in WAIT with flush=1 or redirect same cycle: data discarded, flush<=0, pc<=redirect_pc if redirect, -> REQ.
REQ-027 Redirect in OUT: held instruction discarded even if inst_ready=1, pc<=redirect_pc, -> REQ, no pc+4.
REQ-028 redirect_pc[1:0] SHALL be forced to 0 when loaded; pc+4 wraps modulo 2^XLEN.
REQ-029 Redirect in IDLE SHALL load pc<=redirect_pc; transition to REQ unchanged.

Reset
REQ-030 rst SHALL force state=IDLE, pc=RESET_PC, flush=0, inst=0, inst_pc=0, imem_req_valid=0, inst_valid=0 in the same cycle's update.
REQ-031 rst asserted mid-operation SHALL abandon any outstanding request; a late imem_rsp_valid arriving in IDLE/REQ SHALL be ignored.

Configuration
REQ-032 Macro YSYX_22050039_FETCH_PERF_EN defined: adds outputs perf_fetch_cnt (64, instructions delivered via inst handshake) and perf_flush_cnt (64, responses discarded or OUT instructions dropped), both reset to 0, saturating at all-ones.
REQ-033 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package ysyx_22050039_pkg SHALL hold the FSM state enum, INST_W=32 and the default RESET_PC constant.
REQ-035 The pc register SHALL be one instance of ysyx_22050039_Reg (reset value RESET_PC, write enable 1); the FSM stays in the top module.

Verification
REQ-036 Release rst, imem_req_ready=1, response 1 cycle later, inst_ready=1 -> first imem_req_addr=0x80000000, inst_pc sequence 0x80000000, 0x80000004, 0x80000008, one instruction per 3 cycles.
REQ-037 Hold imem_req_ready=0 for 5 cycles in REQ -> imem_req_valid stays 1, addr stays 0x80000000, no state change.
REQ-038 Redirect to 0x80001003 in WAIT before response -> response dropped, inst_valid never rises for it, next imem_req_addr=0x80001000.
REQ-039 Redirect to 0x80000100 in OUT with inst_ready=1 -> instruction not counted, next fetch 0x80000100.
REQ-040 Assert rst while in WAIT, deliver rsp 1 cycle after reset -> discarded, fetch restarts at 0x80000000.
REQ-041 PERF_EN build, 4 delivered + 1 flush -> perf_fetch_cnt=4, perf_flush_cnt=1.
